sync_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and a registered terminal-count flag. It is the general-purpose counter for the Counters library, replacing fixed 4-bit single-direction counters in timers, dividers and sequencers. Direction is selectable per cycle, and the wrap point is set by parameter rather than by the register width.

---
 rtl/sync_updown_counter.sv | 68 ++++++
 tb/tb_sync_updown_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Parametrised up/down counter with programmable modulus, clamped parallel load and a registered terminal-count flag.
// Define SYNC_UPDOWN_COUNTER_SATURATE_EN to make boundary steps saturate instead of wrapping.
module sync_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_V  = '0;

  // Value taken on a boundary step in each direction.
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_BOUND_V = MAX_V;
  localparam logic [WIDTH-1:0] DN_BOUND_V = ZERO_V;
`else
  localparam logic [WIDTH-1:0] UP_BOUND_V = ZERO_V;
  localparam logic [WIDTH-1:0] DN_BOUND_V = MAX_V;
`endif

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = (din > MAX_V) ? MAX_V : din;
    end else if (en) begin
      if (up) begin
        if (count == MAX_V) begin
          count_nxt = UP_BOUND_V;
          tc_nxt    = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == ZERO_V) begin
          count_nxt = DN_BOUND_V;
          tc_nxt    = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_V;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: a 4-bit MAX=9 instance and an 8-bit full-range instance
// checked against an arithmetic reference model, directed scenarios followed by random traffic.
module tb_sync_updown_counter;

  logic       clk;
  logic       reset;
  logic       en, up, load;
  logic [3:0] din;
  logic [3:0] count;
  logic       tc;
  logic       en8, up8, load8;
  logic [7:0] din8;
  logic [7:0] count8;
  logic       tc8;

  int m4, m8;
  bit mtc4, mtc8;
  int n_checks;
  int n_pass;

`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  sync_updown_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .din(din), .count(count), .tc(tc)
  );

  sync_updown_counter #(.WIDTH(8), .MAX(255), .RESET_VAL(0)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .up(up8), .load(load8),
    .din(din8), .count(count8), .tc(tc8)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: modulus arithmetic on plain integers.
  function automatic void model(inout int m, inout bit t, input int mx,
                                input bit l, input bit e, input bit u, input int d);
    if (l) begin
      m = (d > mx) ? mx : d;
      t = 1'b0;
    end else if (e) begin
      if (u) begin
        t = (m == mx);
        m = SAT ? ((m + 1 > mx) ? mx : m + 1) : (m + 1) % (mx + 1);
      end else begin
        t = (m == 0);
        m = SAT ? ((m - 1 < 0) ? 0 : m - 1) : (m + mx) % (mx + 1);
      end
    end else begin
      t = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count), m4);
    check({tag, ".tc"}, int'(tc), int'(mtc4));
    check({tag, ".count8"}, int'(count8), m8);
    check({tag, ".tc8"}, int'(tc8), int'(mtc8));
  endtask

  // Drive the 4-bit DUT for one edge; the 8-bit DUT uses whatever en8/up8/load8/din8 hold.
  task automatic step(input string tag, input bit l, input bit e, input bit u, input int d);
    load = l; en = e; up = u; din = 4'(d);
    @(posedge clk);
    model(m4, mtc4, 9, l, e, u, d);
    model(m8, mtc8, 255, load8, en8, up8, int'(din8));
    #1;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    m4 = 0; mtc4 = 1'b0; m8 = 0; mtc8 = 1'b0;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b0; en = 0; up = 0; load = 0; din = '0;
    en8 = 0; up8 = 0; load8 = 0; din8 = '0;
    m4 = 0; mtc4 = 0; m8 = 0; mtc8 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // Reset while counting from 6, then count up 1,2,3.
    step("load6_en", 1, 1, 1, 6);
    step("up7", 0, 1, 1, 0);
    mid_reset("rst_mid");
    for (int i = 0; i < 3; i++) step("post_rst_up", 0, 1, 1, 0);

    // Up wrap from 7: 8, 9, 0(tc), 1.
    step("load7", 1, 0, 0, 7);
    for (int i = 0; i < 4; i++) step("up_wrap", 0, 1, 1, 0);
    check("up_wrap.final", int'(count), SAT ? 9 : 1);

    // Down wrap from 2: 1, 0, 9(tc), 8.
    step("load2", 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) step("dn_wrap", 0, 1, 0, 0);

    // Reset while tc is high must clear the pulse.
    step("load9", 1, 0, 0, 9);
    step("up_bound", 0, 1, 1, 0);
    check("tc_before_rst", int'(tc), 1);
    mid_reset("rst_tc");

    // Load priority, clamp, hold.
    step("load5_pri", 1, 1, 0, 5);
    step("load14_clamp", 1, 0, 1, 14);
    check("clamp", int'(count), 9);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 1, 3);
    step("load15_clamp", 1, 1, 1, 15);

    // Direction flip every cycle from 4.
    step("load4", 1, 0, 0, 4);
    for (int i = 0; i < 4; i++) step("flip", 0, 1, (i % 2) == 0, 0);

    // 8-bit full width: 0 down -> 255 with tc.
    load8 = 1; din8 = 8'd0; en8 = 0;
    step("load8_0", 0, 0, 0, 0);
    load8 = 0; en8 = 1; up8 = 0;
    step("w8_down", 0, 0, 0, 0);
    check("w8_down.tc", int'(tc8), 1);
    up8 = 1;
    step("w8_up", 0, 0, 0, 0);
    en8 = 0;

    // Boundary hold attempts (saturate build holds, default wraps).
    step("load8", 1, 0, 0, 8);
    for (int i = 0; i < 4; i++) step("sat_up", 0, 1, 1, 0);
    step("load1", 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("sat_dn", 0, 1, 0, 0);

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      load8 = ($urandom_range(0, 7) == 0);
      en8   = ($urandom_range(0, 3) != 0);
      up8   = $urandom_range(0, 1);
      din8  = 8'($urandom_range(0, 255));
      step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
